// File: rtl/svcs_pkg.sv
// ============================================================================
// svcs_pkg : shared types and constants for the SVCS frame receiver/transmitter
// Revision : 1.0
// ============================================================================
`default_nettype none

package svcs_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      INT  = 2'd1,
      REAL = 2'd2
   } svcs_type_e;

   typedef enum logic [1:0] {
      ST_HDR     = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_HOLD    = 2'd2
   } svcs_rx_state_e;

   localparam logic [3:0] SVCS_MAGIC      = 4'hA;
   localparam int         SVCS_INT_BYTES  = 4;
   localparam int         SVCS_REAL_BYTES = 8;

   function automatic logic svcs_hdr_ok(input logic [7:0] hdr);
      return (hdr[7:4] == SVCS_MAGIC) &&
             ((hdr[3:0] == 4'(INT)) || (hdr[3:0] == 4'(REAL)));
   endfunction

   function automatic logic [2:0] svcs_last_idx(input logic [1:0] typ);
      return (typ == REAL) ? 3'(SVCS_REAL_BYTES - 1) : 3'(SVCS_INT_BYTES - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/svcs_byte_asm.sv
// ============================================================================
// svcs_byte_asm : 64-bit little-endian byte assembler (clear / write at index)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module svcs_byte_asm
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        we,
   input  logic [2:0]  idx,
   input  logic [7:0]  din,
   output logic [63:0] data
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         data <= '0;
      end else if (we) begin
         data[{idx, 3'b000} +: 8] <= din;
      end
   end

endmodule

`default_nettype wire

// File: rtl/svcs_frame_rx.sv
// ============================================================================
// svcs_frame_rx : decodes SVCS header+payload byte frames into INT/REAL words
// Revision      : 1.0
// ============================================================================
`default_nettype none

module svcs_frame_rx
   import svcs_pkg::*;
#(
   parameter int ERR_CNT_W = 16,
   parameter int FRM_CNT_W = 32
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [7:0]           in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           out_type,
   output logic [63:0]          out_data,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [FRM_CNT_W-1:0] frm_cnt
);

   svcs_rx_state_e state;
   logic [2:0]     idx;
   logic           in_fire;
   logic           hdr_ok;
   logic           asm_clr;
   logic           asm_we;

   assign in_fire = in_valid && in_ready;
   assign hdr_ok  = svcs_hdr_ok(in_data);
   assign asm_clr = (state == ST_HDR) && in_fire && hdr_ok;
   assign asm_we  = (state == ST_PAYLOAD) && in_fire;

   // The assembly register doubles as the output data register.
   svcs_byte_asm u_asm (
      .clk  (clk),
      .rst  (rst),
      .clr  (asm_clr),
      .we   (asm_we),
      .idx  (idx),
      .din  (in_data),
      .data (out_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_HDR;
         idx       <= 3'd0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_type  <= 2'(NONE);
         err_pulse <= 1'b0;
         err_cnt   <= '0;
         frm_cnt   <= '0;
      end else begin
         err_pulse <= 1'b0;
         case (state)
            ST_HDR: begin
               in_ready <= 1'b1;
               if (in_fire) begin
                  if (hdr_ok) begin
                     out_type <= in_data[1:0];
                     idx      <= 3'd0;
                     state    <= ST_PAYLOAD;
                  end else begin
                     err_pulse <= 1'b1;
                     if (err_cnt != '1) begin
                        err_cnt <= err_cnt + ERR_CNT_W'(1);
                     end
                  end
               end
            end
            ST_PAYLOAD: begin
               if (in_fire) begin
                  idx <= idx + 3'd1;
                  if (idx == svcs_last_idx(out_type)) begin
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (out_valid && out_ready) begin
                  frm_cnt   <= frm_cnt + FRM_CNT_W'(1);
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_HDR;
               end
            end
            default: begin
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               state     <= ST_HDR;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_svcs_frame_rx.sv
// ============================================================================
// tb_svcs_frame_rx : directed and randomized self-checking bench for svcs_frame_rx
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_svcs_frame_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [1:0]  out_type;
   logic [63:0] out_data;
   logic        err_pulse;
   logic [15:0] err_cnt;
   logic [31:0] frm_cnt;

   int errors = 0;
   int checks = 0;

   svcs_frame_rx #(.ERR_CNT_W(16), .FRM_CNT_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_type  (out_type),
      .out_data  (out_data),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt),
      .frm_cnt   (frm_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offer one byte after an optional idle gap; returns just after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int gap_max);
      logic acc;
      int   n;
      if (gap_max > 0) step($urandom_range(0, gap_max));
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      do begin
         acc = in_ready;
         step(1);
         n++;
      end while (!acc && n < 200);
      in_valid = 1'b0;
      chk("in_accept_timeout", {63'd0, acc}, 64'd1);
   endtask

   task automatic send_frame(input logic [7:0] hdr, input logic [63:0] d,
                             input int nb, input int gap_max);
      send_byte(hdr, gap_max);
      for (int i = 0; i < nb; i++) send_byte(d[8*i +: 8], gap_max);
   endtask

   logic [65:0] sb[$];
   int          err_exp;
   logic [63:0] hold_data;

   initial begin
      // Reset state
      rst = 1'b1;
      step(2);
      chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_type",  {62'd0, out_type},  64'd0);
      chk("rst_out_data",  out_data,           64'd0);
      chk("rst_err_pulse", {63'd0, err_pulse}, 64'd0);
      chk("rst_err_cnt",   {48'd0, err_cnt},   64'd0);
      chk("rst_frm_cnt",   {32'd0, frm_cnt},   64'd0);
      rst = 1'b0;
      step(1);
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      // INT decode
      out_ready = 1'b1;
      send_frame(8'hA1, 64'h0000_0000_1234_5678, 4, 0);
      chk("int_valid", {63'd0, out_valid}, 64'd1);
      chk("int_in_ready_low", {63'd0, in_ready}, 64'd0);
      chk("int_type", {62'd0, out_type}, 64'd1);
      chk("int_data", out_data, 64'h0000_0000_1234_5678);
      step(1);
      chk("int_valid_drop", {63'd0, out_valid}, 64'd0);
      chk("int_frm_cnt", {32'd0, frm_cnt}, 64'd1);

      // REAL decode (1.0)
      send_frame(8'hA2, 64'h3FF0_0000_0000_0000, 8, 0);
      chk("real_valid", {63'd0, out_valid}, 64'd1);
      chk("real_type", {62'd0, out_type}, 64'd2);
      chk("real_data", out_data, 64'h3FF0_0000_0000_0000);
      step(1);
      chk("real_frm_cnt", {32'd0, frm_cnt}, 64'd2);

      // Bad headers followed by a valid INT frame
      send_byte(8'h55, 0);
      chk("bad1_pulse", {63'd0, err_pulse}, 64'd1);
      chk("bad1_cnt", {48'd0, err_cnt}, 64'd1);
      send_byte(8'hB1, 0);
      chk("bad2_pulse", {63'd0, err_pulse}, 64'd1);
      chk("bad2_cnt", {48'd0, err_cnt}, 64'd2);
      send_byte(8'hA1, 0);
      chk("good_hdr_no_pulse", {63'd0, err_pulse}, 64'd0);
      send_frame(8'h01, 64'h0, 0, 0);
      for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
      chk("after_bad_data", out_data, 64'h1);
      chk("after_bad_type", {62'd0, out_type}, 64'd1);
      step(1);
      chk("after_bad_frm_cnt", {32'd0, frm_cnt}, 64'd3);
      chk("after_bad_err_cnt", {48'd0, err_cnt}, 64'd2);

      // Backpressure: 5 stalled cycles then accept
      out_ready = 1'b0;
      send_frame(8'hA1, 64'h0000_0000_DEAD_BEEF, 4, 0);
      hold_data = out_data;
      chk("bp_data", hold_data, 64'h0000_0000_DEAD_BEEF);
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
         chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_data_stable", out_data, 64'h0000_0000_DEAD_BEEF);
         step(1);
      end
      chk("bp_frm_cnt_held", {32'd0, frm_cnt}, 64'd3);
      out_ready = 1'b1;
      chk("bp_still_valid", {63'd0, out_valid}, 64'd1);
      step(1);
      chk("bp_released", {63'd0, out_valid}, 64'd0);
      chk("bp_frm_cnt", {32'd0, frm_cnt}, 64'd4);

      // Reset mid-payload discards the partial frame
      send_byte(8'hA1, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      rst = 1'b1;
      step(1);
      chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("midrst_frm_cnt", {32'd0, frm_cnt}, 64'd0);
      chk("midrst_data", out_data, 64'd0);
      rst = 1'b0;
      send_frame(8'hA1, 64'h0000_0000_0102_0304, 4, 0);
      chk("midrst_word_data", out_data, 64'h0000_0000_0102_0304);
      chk("midrst_word_valid", {63'd0, out_valid}, 64'd1);
      step(1);
      chk("midrst_one_word", {63'd0, out_valid}, 64'd0);
      chk("midrst_frm_cnt1", {32'd0, frm_cnt}, 64'd1);
      chk("midrst_err_cnt0", {48'd0, err_cnt}, 64'd0);

      // Random gaps and backpressure over 1000 mixed frames
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(1);
      err_exp = 0;
      fork
         begin
            logic        is_real;
            logic [63:0] d;
            for (int f = 0; f < 1000; f++) begin
               if ($urandom_range(0, 9) == 0) begin
                  send_byte({4'h5, 4'($urandom)}, 2);
                  err_exp++;
               end
               is_real = 1'($urandom_range(0, 1));
               d = is_real ? {32'($urandom), 32'($urandom)} : {32'd0, 32'($urandom)};
               sb.push_back({(is_real ? 2'd2 : 2'd1), d});
               send_frame(is_real ? 8'hA2 : 8'hA1, d, is_real ? 8 : 4, 2);
            end
         end
         begin
            int          got;
            int          cyc;
            logic [65:0] exp;
            got = 0;
            cyc = 0;
            while (got < 1000 && cyc < 60000) begin
               out_ready = ($urandom_range(0, 3) != 0);
               chk("rand_rdy_vld_excl", {63'd0, in_ready & out_valid}, 64'd0);
               if (out_valid && out_ready) begin
                  chk("rand_sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
                  exp = (sb.size() != 0) ? sb.pop_front() : 66'd0;
                  chk("rand_type", {62'd0, out_type}, {62'd0, exp[65:64]});
                  chk("rand_data", out_data, exp[63:0]);
                  got++;
               end
               step(1);
               cyc++;
            end
            chk("rand_words", 64'(got), 64'd1000);
         end
      join
      chk("rand_frm_cnt", {32'd0, frm_cnt}, 64'd1000);
      chk("rand_err_cnt", {48'd0, err_cnt}, 64'(err_exp));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/svcs_frame_rx.md
# svcs_frame_rx

Hardware receive end of the SVCS (System Verilog client server handshake) link. The host-side SVCS send calls (`send_int`, `send_real`) serialize values into a byte stream. This block decodes that stream back into typed 32-bit integer or 64-bit real words. It sits between the socket-bridge byte source and the device-side consumer, with valid/ready handshakes on both sides.

## Interface

Parameters:
- `ERR_CNT_W`, 16, width of the saturating bad-header counter.
- `FRM_CNT_W`, 32, width of the wrapping good-frame counter.

Ports:
- `clk` input 1: the single clock. Reset is synchronous and active-high.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: a byte is offered on `in_data`.
- `in_ready` output 1: the block accepts the offered byte this cycle.
- `in_data` input 8: byte stream from the socket bridge.
- `out_valid` output 1: a decoded word is present.
- `out_ready` input 1: the consumer accepts the word.
- `out_type` output 2: the word type, from the package enum (1 = INT, 2 = REAL).
- `out_data` output 64: the decoded value. For INT, the value occupies bits [31:0] and bits [63:32] are zero.
- `err_pulse` output 1: one-cycle pulse when a header byte is rejected.
- `err_cnt` output `ERR_CNT_W`: count of rejected header bytes; saturates at its maximum.
- `frm_cnt` output `FRM_CNT_W`: count of words delivered to the consumer; wraps.

## Operation

- Frame format: one header byte, then the payload, least-significant byte first.
  - Header bits [7:4] must equal the magic value 4'hA.
  - Header bits [3:0] give the type: 4'h1 is INT, followed by 4 payload bytes; 4'h2 is REAL (IEEE-754 double), followed by 8 payload bytes.
- FSM states: HDR, PAYLOAD, HOLD.
- HDR:
  - `in_ready` = 1.
  - When a byte is accepted with a valid header: latch the type, clear the byte index and the assembly register, then go to PAYLOAD.
  - When a byte is accepted with the wrong magic or a type other than 1 or 2: drop the byte, pulse `err_pulse`, increment `err_cnt` (saturating), and stay in HDR.
- PAYLOAD:
  - `in_ready` = 1.
  - Each accepted byte is written to bits [8*idx+7 : 8*idx], and the 3-bit index increments.
  - When the last byte is accepted (idx = 3 for INT, idx = 7 for REAL), go to HOLD.
- HOLD:
  - `in_ready` = 0 and `out_valid` = 1; `out_type` and `out_data` stay stable.
  - On `out_valid && out_ready`: increment `frm_cnt` (wrapping) and go to HDR.
- `in_ready` and `out_valid` are never both 1 in the same cycle. Ready and valid are registered state decodes; there is no combinational path from input to output.
- Reset:
  - Outputs: `in_ready`=0 during reset, `out_valid`=0, `out_type`=0, `out_data`=0, `err_pulse`=0, `err_cnt`=0, `frm_cnt`=0.
  - The FSM returns to HDR and a partial frame is discarded.
  - `in_ready` rises in the first cycle after `rst` deasserts.
- A header byte with the magic high nibble set mid-payload has no special meaning; it is treated as payload data. The block does not resynchronize within a frame.

## Timing

- Latency: `out_valid` asserts in the cycle after the final payload byte is accepted.
- INT frame with no stalls: 5 input cycles plus 1 HOLD cycle gives a 6-cycle throughput per word when `out_ready` is held at 1.
- REAL frame with no stalls: 10 cycles per word.
- `err_pulse` asserts in the cycle after the bad byte is accepted and lasts exactly 1 cycle. Back-to-back bad bytes give consecutive pulses.
- `err_cnt` and `frm_cnt` update in the cycle after their triggering event.
- Gaps in `in_valid` are allowed at any point; the FSM state and the index hold during a gap.
- Backpressure: while `out_ready` is 0 in HOLD, `in_ready` stays 0 indefinitely and `out_data` stays unchanged.

## Structure

- Shared package `svcs_pkg`:
  - `svcs_type_e` enum (NONE = 0, INT = 1, REAL = 2).
  - `SVCS_MAGIC` = 4'hA.
  - Payload byte counts `SVCS_INT_BYTES` = 4 and `SVCS_REAL_BYTES` = 8.
  - The FSM state enum.
- The future transmitter `svcs_frame_tx` reuses the same package.
- One sub-module, `svcs_byte_asm`: a 64-bit little-endian byte assembler with clear, write-enable and 3-bit index inputs. The FSM and counters stay in the top level.

## Test plan

1. INT decode: bytes A1 78 56 34 12 with `out_ready`=1 → `out_valid` for 1 cycle, `out_type`=1, `out_data`=0x0000_0000_1234_5678, `frm_cnt`=1.
2. REAL decode: bytes A2 00 00 00 00 00 00 F0 3F → `out_type`=2, `out_data`=0x3FF0_0000_0000_0000 (1.0).
3. Bad headers: bytes 55 B1 then a valid INT frame A1 01 00 00 00 → two `err_pulse` cycles, `err_cnt`=2, then `out_data`=0x1.
4. Backpressure: hold `out_ready`=0 for 5 cycles after the INT frame completes → `in_ready`=0 and `out_data` stable for all 5 cycles; the word is accepted on the 6th cycle with `out_ready`=1.
5. Reset mid-payload: A1 AA BB, then `rst` for 1 cycle, then A1 04 03 02 01 → exactly one word, `out_data`=0x0102_0304, `frm_cnt`=1, `err_cnt`=0.
6. Random `in_valid` gaps combined with random `out_ready` over 1000 mixed frames → decoded words match a scoreboard and `frm_cnt`=1000.
